// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and defaults for the scoreboarded register file.
//               Holds the INIT/RUN controller state encoding and the default
//               register width / register count.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Controller state: INIT clears storage one word per cycle, RUN is normal use.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREG   = 32;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy (pending) bit vector with one set port, one
//               clear port and two combinational lookup ports. When the set
//               and the clear hit the same register on one edge, the set
//               wins. Register 0 is never busy.
// Ports       : clk, resetn (async active-low)
//               set_en/set_addr   - mark register pending
//               clr_en/clr_addr   - mark register complete
//               look1/look2       - lookup addresses
//               busy1/busy2       - busy bit of the looked-up registers
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] look1,
    input  logic [AW-1:0] look2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        // Clear first so that a coincident set overrides it.
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[look1];
    assign busy2 = busy_q[look2];

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Two-read / one-write register file with byte-lane write
//               enables, a busy scoreboard, and a self-clearing INIT phase
//               that zeroes every register after reset. Register 0 reads as
//               zero and ignores writes and scoreboard sets.
// Config      : RF_BYPASS_EN - when defined, reads forward same-cycle write
//               data per byte lane and report the register as not busy
//               unless it is also being set pending that cycle.
// Ports       : clk, resetn (async active-low), init_done
//               raddr1/raddr2 -> rdata1/rdata2, rbusy1/rbusy2
//               we (per byte), waddr, wdata  - write port
//               sb_set, sb_addr              - scoreboard set port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  init_done,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  sb_set,
    input  logic [$clog2(NREG)-1:0] sb_addr
);

    localparam int AW = $clog2(NREG);
    localparam int NB = DATA_W / 8;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];

    logic run;
    logic wr_any;
    logic busy_lu1, busy_lu2;

    assign run       = (state_q == ST_RUN);
    assign wr_any    = run && (|we);
    assign init_done = run;

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------- storage
    // Storage has no reset; it is zeroed by the INIT sweep instead.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (!run) begin
            rf_d[cnt_q] = '0;
        end else if (waddr != '0) begin
            for (int b = 0; b < NB; b++) begin
                if (we[b]) begin
                    rf_d[waddr][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= rf_d[i];
        end
    end

    // -------------------------------------------------------------- scoreboard
    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .resetn   (resetn),
        .set_en   (run && sb_set),
        .set_addr (sb_addr),
        .clr_en   (wr_any),
        .clr_addr (waddr),
        .look1    (raddr1),
        .look2    (raddr2),
        .busy1    (busy_lu1),
        .busy2    (busy_lu2)
    );

    // ------------------------------------------------------------------ reads
    logic [AW-1:0]     ra   [2];
    logic              blu  [2];
    logic [DATA_W-1:0] rd   [2];
    logic              rb   [2];

    always_comb begin
        ra[0]  = raddr1;
        ra[1]  = raddr2;
        blu[0] = busy_lu1;
        blu[1] = busy_lu2;
        for (int p = 0; p < 2; p++) begin
            rd[p] = '0;
            rb[p] = 1'b0;
            if (run && (ra[p] != '0)) begin
                rd[p] = rf_q[ra[p]];
                rb[p] = blu[p];
`ifdef RF_BYPASS_EN
                // Forward written lanes; a completing write makes the register
                // look free unless it is re-marked pending on the same edge.
                if (wr_any && (waddr == ra[p])) begin
                    for (int b = 0; b < NB; b++) begin
                        if (we[b]) begin
                            rd[p][b*8 +: 8] = wdata[b*8 +: 8];
                        end
                    end
                    rb[p] = sb_set && (sb_addr == ra[p]);
                end
`endif
            end
        end
    end

    assign rdata1 = rd[0];
    assign rdata2 = rd[1];
    assign rbusy1 = rb[0];
    assign rbusy2 = rb[1];

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        resetn;
    logic        init_done;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        rbusy1, rbusy2;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sb_set;
    logic [4:0]  sb_addr;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .clk       (clk),
        .resetn    (resetn),
        .init_done (init_done),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .rbusy1    (rbusy1),
        .rbusy2    (rbusy2),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = 4'h0;
        waddr   = 5'd0;
        wdata   = 32'h0;
        sb_set  = 1'b0;
        sb_addr = 5'd0;
    endtask

    // Runs the 32-cycle clear after reset release, checking init_done each cycle.
    task automatic wait_init(input string tag);
        logic exp;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp = (i == 32);
            total++;
            if (init_done !== exp) begin
                bad++;
                $display("FAIL %s init_done cycle %0d: got %b want %b", tag, i, init_done, exp);
            end
        end
    endtask

    task automatic test_reset();
        idle();
        raddr1 = 5'd5;
        raddr2 = 5'd4;
        resetn = 1'b0;
        #1;
        total++;
        if (init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_init_done: got %b want 0", init_done);
        end
        tick();
        tick();
        resetn = 1'b1;
        // Writes and scoreboard sets during INIT must be ignored.
        we = 4'hF; waddr = 5'd4; wdata = 32'hDEADBEEF;
        sb_set = 1'b1; sb_addr = 5'd4;
        #1;
        total++;
        if (rdata1 !== 32'h0 || rbusy2 !== 1'b0) begin
            bad++;
            $display("FAIL init_reads: rdata1=%h rbusy2=%b want 0/0", rdata1, rbusy2);
        end
        wait_init("first");
        idle();
        #1;
        total++;
        if (rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL reg5_after_init: got %h want 00000000", rdata1);
        end
        total++;
        if (rdata2 !== 32'h0 || rbusy2 !== 1'b0) begin
            bad++;
            $display("FAIL init_ignores_write: rdata2=%h rbusy2=%b want 0/0", rdata2, rbusy2);
        end
    endtask

    task automatic test_byte_write();
        raddr1 = 5'd3;
        we = 4'hF; waddr = 5'd3; wdata = 32'h11223344;
        tick();
        idle();
        #1;
        total++;
        if (rdata1 !== 32'h11223344) begin
            bad++;
            $display("FAIL full_write: got %h want 11223344", rdata1);
        end
        we = 4'b0101; waddr = 5'd3; wdata = 32'hAABBCCDD;
        tick();
        idle();
        #1;
        total++;
        if (rdata1 !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL byte_write: got %h want 11bb33dd", rdata1);
        end
    endtask

    task automatic test_scoreboard();
        raddr1 = 5'd7;
        raddr2 = 5'd6;
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        idle();
        #1;
        total++;
        if (rbusy1 !== 1'b1 || rbusy2 !== 1'b0) begin
            bad++;
            $display("FAIL sb_set: rbusy1=%b rbusy2=%b want 1/0", rbusy1, rbusy2);
        end
        we = 4'hF; waddr = 5'd7; wdata = 32'h00000001;
        tick();
        idle();
        #1;
        total++;
        if (rbusy1 !== 1'b0) begin
            bad++;
            $display("FAIL sb_clear: got %b want 0", rbusy1);
        end
        we = 4'hF; waddr = 5'd7; wdata = 32'h00000055;
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        idle();
        #1;
        total++;
        if (rbusy1 !== 1'b1 || rdata1 !== 32'h00000055) begin
            bad++;
            $display("FAIL set_wins: rbusy1=%b rdata1=%h want 1/00000055", rbusy1, rdata1);
        end
        we = 4'b0010; waddr = 5'd7; wdata = 32'h0000AA00;
        tick();
        idle();
        #1;
        total++;
        if (rbusy1 !== 1'b0 || rdata1 !== 32'h0000AA55) begin
            bad++;
            $display("FAIL partial_clear: rbusy1=%b rdata1=%h want 0/0000aa55", rbusy1, rdata1);
        end
    endtask

    task automatic test_addr0();
        raddr1 = 5'd0;
        we = 4'hF; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        idle();
        #1;
        total++;
        if (rdata1 !== 32'h0 || rbusy1 !== 1'b0) begin
            bad++;
            $display("FAIL addr0: rdata1=%h rbusy1=%b want 0/0", rdata1, rbusy1);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_d;
        logic        exp_b;
        raddr2 = 5'd9;
        we = 4'hF; waddr = 5'd9; wdata = 32'h12345678;
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle();
        we = 4'hF; waddr = 5'd9; wdata = 32'hCAFEF00D;
        #1;
`ifdef RF_BYPASS_EN
        exp_d = 32'hCAFEF00D;
        exp_b = 1'b0;
`else
        exp_d = 32'h12345678;
        exp_b = 1'b1;
`endif
        total++;
        if (rdata2 !== exp_d || rbusy2 !== exp_b) begin
            bad++;
            $display("FAIL same_cycle: rdata2=%h rbusy2=%b want %h/%b", rdata2, rbusy2, exp_d, exp_b);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdata2 !== 32'hCAFEF00D || rbusy2 !== 1'b0) begin
            bad++;
            $display("FAIL after_write: rdata2=%h rbusy2=%b want cafef00d/0", rdata2, rbusy2);
        end
    endtask

    task automatic test_reset_mid();
        // Populate data and busy bits, then reset during RUN.
        we = 4'hF; waddr = 5'd12; wdata = 32'h0BADF00D;
        tick();
        idle();
        sb_set = 1'b1; sb_addr = 5'd12;
        tick();
        sb_addr = 5'd20;
        tick();
        idle();
        resetn = 1'b0;
        #1;
        total++;
        if (init_done !== 1'b0) begin
            bad++;
            $display("FAIL run_reset_init_done: got %b want 0", init_done);
        end
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        // Second reset ten cycles into INIT must restart the full sweep.
        resetn = 1'b0;
        #2;
        total++;
        if (init_done !== 1'b0) begin
            bad++;
            $display("FAIL init_reset_init_done: got %b want 0", init_done);
        end
        tick();
        resetn = 1'b1;
        wait_init("restart");
        for (int r = 0; r < 32; r++) begin
            raddr1 = 5'(r);
            #1;
            total++;
            if (rdata1 !== 32'h0 || rbusy1 !== 1'b0) begin
                bad++;
                $display("FAIL cleared_reg%0d: rdata1=%h rbusy1=%b want 0/0", r, rdata1, rbusy1);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        idle();
        test_reset();
        test_byte_write();
        test_scoreboard();
        test_addr0();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
